// File: rtl/latch_ctrl_pkg.sv
// latch_ctrl_pkg: shared types and constants for the latch bank write controller.
//   state_t    - controller FSM states
//   CLEAR_CYC  - number of cycles the bank reset (LR) is held low for a clear
//   addr_w()   - index width for a count of n items (never less than 1 bit)
package latch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    OPEN,
    HOLD,
    CLEAR
  } state_t;

  localparam int unsigned CLEAR_CYC = 2;

  function automatic int unsigned addr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with an internal priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset (pointer returns to 0)
//   req        : request vector
//   adv        : strobe, moves the pointer to one past adv_idx
//   adv_idx    : index of the grant being retired
//   grant      : one-hot grant (zero when no request)
//   gidx       : index of the granted requester
//   gany       : at least one request is present
module rr_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = addr_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  input  logic [IW-1:0]   adv_idx,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   gidx,
  output logic            gany
);

  logic [IW-1:0]     ptr;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IW-1:0]     off;
  logic [IW:0]       sum;

  // Rotate the request vector so the pointer position becomes bit 0, take the
  // first set bit, then map the offset back to an absolute index modulo NREQ.
  always_comb begin
    dbl  = {req, req};
    rot  = NREQ'(dbl >> ptr);
    gany = 1'b0;
    off  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!gany && rot[k]) begin
        gany = 1'b1;
        off  = IW'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IW+1)'(NREQ)) begin
      sum = sum - (IW+1)'(NREQ);
    end
    gidx  = sum[IW-1:0];
    grant = gany ? (NREQ'(1) << gidx) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (adv_idx == IW'(NREQ-1)) ? '0 : adv_idx + IW'(1);
    end
  end

endmodule

// File: rtl/latch_bank_write_ctrl.sv
// latch_bank_write_ctrl: sequences writes from NREQ requesters into a bank of
// NLAT level-sensitive D-latches with a setup -> open -> hold discipline, and
// sequences a bank-wide clear through the latches' active-low reset.
//   CLK   : clock
//   R     : asynchronous active-low reset
//   REQ   : per-requester write request (level, held until ACK)
//   ADDR  : per-requester entry address, requester i at [i*AW +: AW]
//   WDATA : per-requester write data, requester i at [i*W +: W]
//   CLR   : bank clear request pulse
//   ACK   : one-cycle one-hot write-complete pulse
//   BUSY  : controller not idle
//   LD    : shared latch D bus
//   LEN   : one-hot latch enables
//   LR    : latch bank reset, active-low
// All outputs are registered; their next values are derived from the next state.
module latch_bank_write_ctrl
  import latch_ctrl_pkg::*;
#(
  parameter  int unsigned NREQ     = 4,
  parameter  int unsigned NLAT     = 8,
  parameter  int unsigned W        = 8,
  parameter  int unsigned OPEN_CYC = 2,
  localparam int unsigned AW       = addr_w(NLAT)
) (
  input  logic              CLK,
  input  logic              R,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ*AW-1:0] ADDR,
  input  logic [NREQ*W-1:0] WDATA,
  input  logic              CLR,
  output logic [NREQ-1:0]   ACK,
  output logic              BUSY,
  output logic [W-1:0]      LD,
  output logic [NLAT-1:0]   LEN,
  output logic              LR
);

  localparam int unsigned IW = addr_w(NREQ);
  localparam int unsigned CW = addr_w((OPEN_CYC > CLEAR_CYC) ? OPEN_CYC : CLEAR_CYC);

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [AW-1:0]     addr_q, addr_n;
  logic [NREQ-1:0]   sel_q, sel_n;
  logic [IW-1:0]     gidx_q, gidx_n;
  logic              clr_pend, clr_pend_n;
  logic [W-1:0]      ld_n;
  logic [NLAT-1:0]   len_n;
  logic [NREQ-1:0]   ack_n;
  logic              busy_n;
  logic              lr_n;

  logic [NREQ-1:0]   grant;
  logic [IW-1:0]     gidx;
  logic              gany;
  logic              adv;

  assign adv = (state == HOLD);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (CLK),
    .rst_n   (R),
    .req     (REQ),
    .adv     (adv),
    .adv_idx (gidx_q),
    .grant   (grant),
    .gidx    (gidx),
    .gany    (gany)
  );

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    addr_n     = addr_q;
    sel_n      = sel_q;
    gidx_n     = gidx_q;
    ld_n       = LD;
    clr_pend_n = clr_pend | CLR;

    unique case (state)
      IDLE: begin
        if (clr_pend) begin
          state_n    = CLEAR;
          cnt_n      = '0;
          ld_n       = '0;
          // a pulse arriving in the servicing cycle stays pending
          clr_pend_n = CLR;
        end else if (gany) begin
          state_n = SETUP;
          addr_n  = ADDR[gidx*AW +: AW];
          ld_n    = WDATA[gidx*W +: W];
          sel_n   = grant;
          gidx_n  = gidx;
        end
      end
      SETUP: begin
        state_n = OPEN;
        cnt_n   = '0;
      end
      OPEN: begin
        if (cnt == CW'(OPEN_CYC - 1)) begin
          state_n = HOLD;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      HOLD: begin
        state_n = IDLE;
      end
      CLEAR: begin
        ld_n = '0;
        if (cnt == CW'(CLEAR_CYC - 1)) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Out-of-range addresses match no entry, so LEN stays zero for them.
    len_n = '0;
    for (int unsigned i = 0; i < NLAT; i++) begin
      len_n[i] = (state_n == OPEN) && (addr_q == AW'(i));
    end
    ack_n  = (state_n == HOLD) ? sel_q : '0;
    busy_n = (state_n != IDLE);
    lr_n   = (state_n != CLEAR);
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      sel_q    <= '0;
      gidx_q   <= '0;
      clr_pend <= 1'b0;
      LD       <= '0;
      LEN      <= '0;
      ACK      <= '0;
      BUSY     <= 1'b0;
      LR       <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      addr_q   <= addr_n;
      sel_q    <= sel_n;
      gidx_q   <= gidx_n;
      clr_pend <= clr_pend_n;
      LD       <= ld_n;
      LEN      <= len_n;
      ACK      <= ack_n;
      BUSY     <= busy_n;
      LR       <= lr_n;
    end
  end

endmodule
